// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared types and default timing constants for the push-button
//               debouncer (12 MHz board clock).
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

  // Number of independent button channels
  localparam int NUM_BTN = 2;

  // Default timing at 12 MHz
  localparam int DEF_DEBOUNCE_CYCLES = 240000;   // 20 ms
  localparam int DEF_HOLD_CYCLES     = 6000000;  // 0.5 s
  localparam int DEF_REPEAT_CYCLES   = 1200000;  // 0.1 s
  localparam int DEF_CNT_W           = 24;

  // Per-channel debounce state
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

endpackage : button_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button channel: 2-flop synchroniser, debounce FSM with
//               debounce/hold counters, registered level/press/release/repeat.
//               Input is already polarity-normalised (1 = pressed).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pressed_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  // Terminal counts; the counters never advance past these values
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             sync1_q, sync2_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             first_q, first_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic [CNT_W-1:0] hold_limit;

  // First repeat waits the long hold time, later repeats use the short period
  assign hold_limit = first_q ? HOLD_LAST : REP_LAST;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: debounce FSM, counters and one-cycle pulse generation
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    first_d   = first_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_DB_PRESS;
          dcnt_d  = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (dcnt_q >= DB_LAST) begin
          state_d = ST_HELD;
          hcnt_d  = '0;
          first_d = 1'b1;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          // hcnt is frozen so a short glitch only delays the repeat schedule
          state_d = ST_DB_RELEASE;
          dcnt_d  = '0;
        end else if (hcnt_q >= hold_limit) begin
          repeat_d = 1'b1;
          hcnt_d   = '0;
          first_d  = 1'b0;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        if (sync2_q) begin
          state_d = ST_HELD;
        end else if (dcnt_q >= DB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    level_d = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      first_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      first_q   <= first_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-button conditioning stage: polarity normalisation, then
//               one independent synchronise/debounce/auto-repeat channel per
//               button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int ACTIVE_HIGH     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] pmod,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  // Inverting mask applied before the synchroniser so reset means "released"
  localparam logic [NUM_BTN-1:0] INV_MASK = (ACTIVE_HIGH != 0) ? '0 : '1;

  logic [NUM_BTN-1:0] w_pressed;

  assign w_pressed = pmod ^ INV_MASK;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .pressed_i (w_pressed[gi]),
      .level_o   (btn_level[gi]),
      .press_o   (btn_press[gi]),
      .release_o (btn_release[gi]),
      .repeat_o  (btn_repeat[gi])
    );
  end

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debouncer
// Description : Directed self-checking bench. Expected pulse events are queued
//               with their cycle number when stimulus is driven and compared
//               against the DUT pulses on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  // A change driven at falling edge of cycle n yields its pulse at cycle n+LAT
  localparam int LAT  = DB + 3;

  typedef struct {
    int          cyc;
    logic [11:0] ev;   // [5:0] active-high DUT, [11:6] active-low DUT
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] pmod, pmod_n;
  logic [1:0] lvl, prs, rel, rpt;
  logic [1:0] lvl_n, prs_n, rel_n, rpt_n;

  int  cyc;
  int  total;
  int  bad;
  ev_t sb[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES (DB), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP),
    .CNT_W (24), .ACTIVE_HIGH (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .pmod (pmod),
    .btn_level (lvl), .btn_press (prs), .btn_release (rel), .btn_repeat (rpt)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DB), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP),
    .CNT_W (24), .ACTIVE_HIGH (0)
  ) dut_n (
    .clk (clk), .rst_n (rst_n), .pmod (pmod_n),
    .btn_level (lvl_n), .btn_press (prs_n), .btn_release (rel_n), .btn_repeat (rpt_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic push(input int c, input logic [11:0] e);
    ev_t x;
    x.cyc = c;
    x.ev  = e;
    sb.push_back(x);
  endtask

  // Clean press at cycle n held for 'hold' cycles: press, repeats, release
  task automatic push_hold(input int base, input logic [1:0] m, input int n, input int hold);
    int p;
    int f;
    int r;
    p = n + LAT;
    f = n + hold;
    r = p + HOLD;
    push(p, 12'(m) << base);
    while (r < f + 3) begin
      push(r, 12'(m) << (base + 4));
      r += REP;
    end
    push(f + LAT, 12'(m) << (base + 2));
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard: every pulse must match the head entry at exactly its cycle
  logic [11:0] obs;
  always @(negedge clk) begin
    obs = {rpt_n, rel_n, prs_n, rpt, rel, prs};
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      check("pulse", 32'(obs), 32'(sb[0].ev));
      void'(sb.pop_front());
    end else if (obs != 12'd0) begin
      check("unexpected_pulse", 32'(obs), 32'd0);
    end
  end

  initial begin
    int n;
    int m;
    int r;
    logic [6:0] pat;
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    pmod   = 2'b00;
    pmod_n = 2'b11;

    // Reset state
    #12;
    check("reset_outputs", 32'({lvl, prs, rel, rpt}), 32'd0);
    check("reset_outputs_n", 32'({lvl_n, prs_n, rel_n, rpt_n}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press/release on button 0
    n = cyc;
    pmod[0] = 1'b1;
    push_hold(0, 2'b01, n, 20);
    goto(n + LAT - 1);
    check("level_before_press", 32'(lvl), 32'd0);
    goto(n + LAT);
    check("level_at_press", 32'(lvl), 32'b01);
    goto(n + 20);
    pmod[0] = 1'b0;
    goto(n + 20 + LAT - 1);
    check("level_before_release", 32'(lvl), 32'b01);
    goto(n + 20 + LAT);
    check("level_after_release", 32'(lvl), 32'd0);
    goto(n + 30);

    // Bounce rejection, then a stable press
    pat = 7'b0110011;
    for (int i = 0; i < 7; i++) begin
      pmod[0] = pat[i];
      @(negedge clk);
    end
    pmod[0] = 1'b1;
    m = cyc;
    push_hold(0, 2'b01, m, 8);
    goto(m + 8);
    pmod[0] = 1'b0;
    goto(m + 18);

    // Auto-repeat on button 1 with a 2-cycle low glitch while held
    n = cyc;
    pmod[1] = 1'b1;
    push(n + 7,  12'b000000_000010);
    push(n + 17, 12'b000000_100000);
    push(n + 20, 12'b000000_100000);
    push(n + 23, 12'b000000_100000);
    // glitch freezes hcnt for three edges (two low samples plus the return edge)
    push(n + 29, 12'b000000_100000);
    push(n + 32, 12'b000000_100000);
    push(n + 35, 12'b000000_100000);
    push(n + 38, 12'b000000_100000);
    push(n + 41, 12'b000000_100000);
    push(n + 47, 12'b000000_001000);
    goto(n + 21);
    pmod[1] = 1'b0;
    goto(n + 23);
    pmod[1] = 1'b1;
    goto(n + 25);
    check("level_during_glitch", 32'(lvl), 32'b10);
    goto(n + 40);
    pmod[1] = 1'b0;
    goto(n + 50);

    // Simultaneous press/release on both buttons
    n = cyc;
    pmod = 2'b11;
    push_hold(0, 2'b11, n, 8);
    goto(n + LAT);
    check("level_both", 32'(lvl), 32'b11);
    goto(n + 8);
    pmod = 2'b00;
    goto(n + 18);

    // Reset while held, button still down on reset release
    n = cyc;
    pmod[0] = 1'b1;
    push(n + LAT, 12'b000000_000001);
    goto(n + 9);
    check("level_before_reset", 32'(lvl), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("outputs_in_reset", 32'({lvl, prs, rel, rpt}), 32'd0);
    repeat (3) @(negedge clk);
    check("outputs_held_in_reset", 32'({lvl, prs, rel, rpt}), 32'd0);
    r = cyc;
    rst_n = 1'b1;
    push_hold(0, 2'b01, r, 8);
    goto(r + 8);
    pmod[0] = 1'b0;
    goto(r + 18);

    // Active-low instance: idle high gives nothing, low is a press
    check("level_n_idle", 32'(lvl_n), 32'd0);
    n = cyc;
    pmod_n[0] = 1'b0;
    push_hold(6, 2'b01, n, 8);
    goto(n + LAT);
    check("level_n_press", 32'(lvl_n), 32'b01);
    goto(n + 8);
    pmod_n[0] = 1'b1;
    goto(n + 20);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_button_debouncer
`default_nettype wire
